invsqrt_rr_sched: RTL and testbench

- Round-robin scheduler that shares one inverse-square-root pipeline among NREQ requesters.
- Arbitrates requests and drives the pipeline's valid/number/backprn inputs.
- Carries each accepted request's requester ID through a tag shift register kept in lockstep with the pipeline.
- Routes each pipeline result and error flag back to the requester that issued it.
- Sits between the front-end request sources and the invsqrt pipeline chain, whose first stage is the init stage.

---
 rtl/invsqrt_rr_sched_pkg.sv | 24 ++
 rtl/invsqrt_rr_sched_if.sv | 34 +++
 rtl/invsqrt_rr_sched_rr_arbiter.sv | 31 +++
 rtl/invsqrt_rr_sched.sv | 96 +++++++++
 tb/tb_invsqrt_rr_sched.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/invsqrt_rr_sched_pkg.sv
// Shared constants, types and helpers for the invsqrt round-robin scheduler.
package invsqrt_rr_sched_pkg;

  localparam int unsigned FP32_W = 32;
  localparam logic [FP32_W-1:0] INVSQRT_MAGIC = 32'h5f3759df;

  // Tag id storage is sized for the largest supported requester count (8).
  localparam int unsigned MAX_IDW = 3;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 1; i < n; i = i * 2) r++;
    return r;
  endfunction

  // One tag pipe entry: occupancy bit plus the issuing requester's id.
  typedef struct packed {
    logic               v;
    logic [MAX_IDW-1:0] id;
  } tag_t;

endpackage

// File: rtl/invsqrt_rr_sched_if.sv
// Request, pipeline and response signals of the invsqrt scheduler.
interface invsqrt_rr_sched_if import invsqrt_rr_sched_pkg::*; #(
  parameter int unsigned NREQ = 4
);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*FP32_W-1:0] req_number;
  logic [NREQ-1:0]        req_ready;

  logic                   pipe_valid;
  logic [FP32_W-1:0]      pipe_number;
  logic                   pipe_backprn;
  logic                   pipe_ready;
  logic [FP32_W-1:0]      pipe_result;
  logic                   pipe_error;

  logic [NREQ-1:0]        rsp_valid;
  logic [FP32_W-1:0]      rsp_result;
  logic                   rsp_error;
  logic                   rsp_stall;

  // Scheduler side
  modport master (
    input  req_valid, req_number, pipe_ready, pipe_result, pipe_error, rsp_stall,
    output req_ready, pipe_valid, pipe_number, pipe_backprn, rsp_valid, rsp_result, rsp_error
  );

  // Requester / pipeline / response-sink side
  modport slave (
    output req_valid, req_number, pipe_ready, pipe_result, pipe_error, rsp_stall,
    input  req_ready, pipe_valid, pipe_number, pipe_backprn, rsp_valid, rsp_result, rsp_error
  );

endinterface

// File: rtl/invsqrt_rr_sched_rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr, wrapping.
module invsqrt_rr_sched_rr_arbiter import invsqrt_rr_sched_pkg::*; #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt_c,
  output logic [IDW-1:0]  idx_c,
  output logic            any_c
);

  logic [IDW-1:0] cand;

  // Rotating priority search starting at ptr
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    cand  = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = IDW'((32'(ptr) + off) % NREQ);
      if (!any_c && req[cand]) begin
        any_c       = 1'b1;
        idx_c       = cand;
        gnt_c[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/invsqrt_rr_sched.sv
// Shares one invsqrt pipeline among NREQ requesters; a tag pipe moving in
// lockstep with the pipeline routes each result back to its requester.
module invsqrt_rr_sched import invsqrt_rr_sched_pkg::*; #(
  parameter  int unsigned NREQ = 4,
  parameter  int unsigned LAT  = 4,
  localparam int unsigned IDW  = clog2(NREQ),
  localparam int unsigned CNTW = clog2(LAT + 1) + 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  invsqrt_rr_sched_if.master   bus,
  output logic [CNTW-1:0]      inflight,
  output logic                 tag_fault
);

  logic              adv;
  logic              accept;
  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    g;
  logic              any_req;
  logic [IDW-1:0]    ptr;
  tag_t              tags [LAT];
  tag_t              tail;
  logic [FP32_W-1:0] slots [NREQ];

  invsqrt_rr_sched_rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .gnt_c (gnt),
    .idx_c (g),
    .any_c (any_req)
  );

  // Unpack the flat operand bus into per-requester slots
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      slots[i] = bus.req_number[i*FP32_W +: FP32_W];
    end
  end

  // Handshake, pipeline drive and response routing
  always_comb begin
    adv              = ~bus.rsp_stall;
    accept           = adv & any_req;
    tail             = tags[LAT-1];
    bus.pipe_backprn = adv;
    bus.req_ready    = adv ? gnt : '0;
    bus.pipe_valid   = accept;
    bus.pipe_number  = any_req ? slots[g] : '0;
    bus.rsp_valid    = bus.pipe_ready ? (NREQ'(1) << tail.id) : '0;
    bus.rsp_result   = bus.pipe_result;
    bus.rsp_error    = bus.pipe_error;
  end

  // Priority pointer moves just past the winner on every transfer
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (32'(g) == NREQ - 1) ? '0 : g + IDW'(1);
    end
  end

  // Tag pipe advances and holds exactly like the pipeline stages
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned k = 0; k < LAT; k++) tags[k] <= '0;
    end else if (adv) begin
      tags[0] <= tag_t'{v: accept, id: MAX_IDW'(g)};
      for (int unsigned k = 1; k < LAT; k++) tags[k] <= tags[k-1];
    end
  end

  // Occupancy: entries accepted minus entries retired from the tail
  always_ff @(posedge clk) begin
    if (!rstn) begin
      inflight <= '0;
    end else if (adv) begin
      if (accept && !tail.v) begin
        inflight <= inflight + CNTW'(1);
      end else if (!accept && tail.v) begin
        inflight <= inflight - CNTW'(1);
      end
    end
  end

  // Sticky flag for a pipeline/tag valid disagreement
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tag_fault <= 1'b0;
    end else if (bus.pipe_ready != tail.v) begin
      tag_fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_invsqrt_rr_sched.sv
// Self-checking bench for invsqrt_rr_sched with a behavioural pipeline
// stand-in and a queue-based reference scoreboard.
module tb_invsqrt_rr_sched;
  import invsqrt_rr_sched_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned LAT  = 4;
  localparam int unsigned CNTW = clog2(LAT + 1) + 1;

  logic            clk;
  logic            rstn;
  logic            inject;
  logic [CNTW-1:0] inflight;
  logic            tag_fault;
  int              checks   = 0;
  int              failures = 0;

  invsqrt_rr_sched_if #(.NREQ(NREQ)) bus ();

  invsqrt_rr_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .inflight  (inflight),
    .tag_fault (tag_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] ref_invsqrt(input logic [31:0] x);
    return INVSQRT_MAGIC - {1'b0, x[31:1]};
  endfunction

  function automatic logic ref_err(input logic [31:0] x);
    return (x[30:0] == 31'd0) || x[31] || (x[30:23] == 8'hFF);
  endfunction

  function automatic logic [31:0] rand_num(input bit allow_err);
    int unsigned sel;
    sel = allow_err ? $urandom_range(0, 7) : 7;
    case (sel)
      0:       return 32'h0000_0000;
      1:       return 32'hBF80_0000;
      2:       return {1'b0, 8'hFF, 23'($urandom)};
      default: return {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
  endfunction

  // Pipeline stand-in: LAT stages that advance only on backprn
  logic [LAT-1:0] pm_v;
  logic [31:0]    pm_n [LAT];
  always @(posedge clk) begin
    if (!rstn) begin
      pm_v <= '0;
    end else if (bus.pipe_backprn) begin
      pm_v[0] <= bus.pipe_valid;
      pm_n[0] <= bus.pipe_number;
      for (int k = 1; k < LAT; k++) begin
        pm_v[k] <= pm_v[k-1];
        pm_n[k] <= pm_n[k-1];
      end
    end
  end
  assign bus.pipe_ready  = pm_v[LAT-1] | inject;
  assign bus.pipe_result = ref_invsqrt(pm_n[LAT-1]);
  assign bus.pipe_error  = ref_err(pm_n[LAT-1]);

  // Reference model: expected responses in issue order, stamped with the
  // advance count at which they were accepted.
  typedef struct {
    int unsigned     id;
    logic [31:0]     num;
    longint unsigned at;
  } exp_t;

  exp_t            sb_q [$];
  int unsigned     sb_ptr, sb_g, sb_i;
  longint unsigned sb_adv;
  logic            sb_fault, sb_due, sb_any;
  logic [NREQ-1:0] sb_rv, sb_gnt;
  logic [31:0]     sb_num;

  initial begin
    sb_ptr = 0; sb_adv = 0; sb_fault = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        sb_q.delete();
        sb_ptr = 0; sb_adv = 0; sb_fault = 1'b0;
      end else begin
        sb_due = 1'b0;
        sb_rv  = '0;
        if (sb_q.size() > 0) begin
          if (sb_q[0].at + longint'(LAT) == sb_adv) begin
            sb_due = 1'b1;
            sb_rv  = NREQ'(1) << sb_q[0].id;
          end
        end
        if (!inject) begin
          checks++;
          if (bus.rsp_valid !== sb_rv) begin
            failures++;
            $display("FAIL sb_rsp_valid: got %b expected %b at %0t", bus.rsp_valid, sb_rv, $time);
          end
          if (sb_due) begin
            checks++;
            if (bus.rsp_result !== ref_invsqrt(sb_q[0].num) || bus.rsp_error !== ref_err(sb_q[0].num)) begin
              failures++;
              $display("FAIL sb_rsp_data: got %h/%b expected %h/%b", bus.rsp_result, bus.rsp_error,
                       ref_invsqrt(sb_q[0].num), ref_err(sb_q[0].num));
            end
          end
        end
        checks++;
        if (inflight !== CNTW'(sb_q.size())) begin
          failures++;
          $display("FAIL sb_inflight: got %0d expected %0d", inflight, sb_q.size());
        end
        checks++;
        if (tag_fault !== sb_fault) begin
          failures++;
          $display("FAIL sb_tag_fault: got %b expected %b", tag_fault, sb_fault);
        end
        sb_any = 1'b0;
        sb_g   = 0;
        for (int unsigned off = 0; off < NREQ; off++) begin
          sb_i = (sb_ptr + off) % NREQ;
          if (!sb_any && bus.req_valid[sb_i]) begin
            sb_any = 1'b1;
            sb_g   = sb_i;
          end
        end
        sb_gnt = (sb_any && !bus.rsp_stall) ? (NREQ'(1) << sb_g) : '0;
        sb_num = sb_any ? bus.req_number[32*sb_g +: 32] : 32'd0;
        checks++;
        if (bus.req_ready !== sb_gnt || bus.pipe_valid !== (sb_any && !bus.rsp_stall) ||
            bus.pipe_number !== sb_num || bus.pipe_backprn !== !bus.rsp_stall) begin
          failures++;
          $display("FAIL sb_grant: got rdy=%b pv=%b pn=%h bp=%b expected rdy=%b pn=%h", bus.req_ready,
                   bus.pipe_valid, bus.pipe_number, bus.pipe_backprn, sb_gnt, sb_num);
        end
        if (inject && !sb_due) sb_fault = 1'b1;
        if (!bus.rsp_stall) begin
          if (sb_due) void'(sb_q.pop_front());
          if (sb_any) begin
            sb_q.push_back('{id: sb_g, num: sb_num, at: sb_adv});
            sb_ptr = (sb_g + 1) % NREQ;
          end
          sb_adv++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.rsp_stall = 1'b0;
    inject        = 1'b0;
    rstn          = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    checks++;
    if (inflight !== '0 || tag_fault !== 1'b0) begin
      failures++;
      $display("FAIL reset_regs: got inflight=%0d fault=%b expected 0/0", inflight, tag_fault);
    end
    checks++;
    if (bus.req_ready !== '0 || bus.rsp_valid !== '0 || bus.pipe_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: got rdy=%b rsp=%b pv=%b expected zeros", bus.req_ready, bus.rsp_valid, bus.pipe_valid);
    end
  endtask

  task automatic test_single();
    logic [NREQ-1:0] exp_rv;
    tick();
    bus.req_number        = '0;
    bus.req_number[31:0]  = 32'h4080_0000;
    bus.req_valid         = 4'b0001;
    #2;
    checks++;
    if (bus.req_ready !== 4'b0001 || bus.pipe_number !== 32'h4080_0000) begin
      failures++;
      $display("FAIL single_accept: got rdy=%b pn=%h expected 0001/40800000", bus.req_ready, bus.pipe_number);
    end
    for (int k = 1; k <= LAT; k++) begin
      tick();
      bus.req_valid = '0;
      #2;
      exp_rv = (k == LAT) ? 4'b0001 : 4'b0000;
      checks++;
      if (bus.rsp_valid !== exp_rv || inflight !== CNTW'(1)) begin
        failures++;
        $display("FAIL single_latency k=%0d: got rsp=%b inflight=%0d expected %b/1", k, bus.rsp_valid, inflight, exp_rv);
      end
    end
    checks++;
    if (bus.rsp_result !== ref_invsqrt(32'h4080_0000) || bus.rsp_error !== 1'b0) begin
      failures++;
      $display("FAIL single_result: got %h/%b expected %h/0", bus.rsp_result, bus.rsp_error, ref_invsqrt(32'h4080_0000));
    end
    tick();
    #2;
    checks++;
    if (inflight !== '0 || bus.rsp_valid !== '0) begin
      failures++;
      $display("FAIL single_retire: got inflight=%0d rsp=%b expected 0/0000", inflight, bus.rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] nums [$];
    int unsigned j;
    do_reset();
    j = 0;
    for (int c = 0; c < 8 + 3 * LAT; c++) begin
      bus.req_valid = (c < 8) ? '1 : '0;
      for (int i = 0; i < NREQ; i++) bus.req_number[32*i +: 32] = rand_num(1'b0);
      #2;
      if (c < 8) begin
        checks++;
        if (bus.req_ready !== (NREQ'(1) << (c % NREQ))) begin
          failures++;
          $display("FAIL rr_grant c=%0d: got %b expected %b", c, bus.req_ready, NREQ'(1) << (c % NREQ));
        end
        nums.push_back(bus.req_number[32*(c % NREQ) +: 32]);
      end
      if (bus.rsp_valid !== '0) begin
        checks++;
        if (j >= nums.size()) begin
          failures++;
          $display("FAIL rr_extra_rsp: got %b expected none", bus.rsp_valid);
        end else if (bus.rsp_valid !== (NREQ'(1) << (j % NREQ)) || bus.rsp_result !== ref_invsqrt(nums[j])) begin
          failures++;
          $display("FAIL rr_rsp j=%0d: got %b/%h expected %b/%h", j, bus.rsp_valid, bus.rsp_result,
                   NREQ'(1) << (j % NREQ), ref_invsqrt(nums[j]));
        end
        j++;
      end
      tick();
    end
    checks++;
    if (j != 8) begin
      failures++;
      $display("FAIL rr_count: got %0d responses expected 8", j);
    end
  endtask

  task automatic test_stall();
    logic [31:0]     nums [$];
    int unsigned     n, j;
    logic [NREQ-1:0] held;
    do_reset();
    n = 0; j = 0; held = '0;
    for (int c = 0; c < 10 + 3 * LAT; c++) begin
      bus.rsp_stall = (c >= 5 && c < 8);
      bus.req_valid = (c < 10) ? '1 : '0;
      for (int i = 0; i < NREQ; i++) bus.req_number[32*i +: 32] = rand_num(1'b0);
      #2;
      if (bus.rsp_stall) begin
        checks++;
        if (bus.req_ready !== '0 || bus.pipe_backprn !== 1'b0) begin
          failures++;
          $display("FAIL stall_block c=%0d: got rdy=%b bp=%b expected 0000/0", c, bus.req_ready, bus.pipe_backprn);
        end
        checks++;
        if (c == 5) begin
          held = bus.rsp_valid;
          // five accepts before the stall: the second one is at the tail
          if (held !== 4'b0010) begin
            failures++;
            $display("FAIL stall_present: got %b expected 0010", held);
          end
        end else if (bus.rsp_valid !== held) begin
          failures++;
          $display("FAIL stall_hold c=%0d: got %b expected %b", c, bus.rsp_valid, held);
        end
      end else begin
        if (bus.rsp_valid !== '0) begin
          checks++;
          if (j >= nums.size()) begin
            failures++;
            $display("FAIL stall_extra_rsp: got %b expected none", bus.rsp_valid);
          end else if (bus.rsp_valid !== (NREQ'(1) << (j % NREQ)) || bus.rsp_result !== ref_invsqrt(nums[j])) begin
            failures++;
            $display("FAIL stall_rsp j=%0d: got %b/%h expected %b/%h", j, bus.rsp_valid, bus.rsp_result,
                     NREQ'(1) << (j % NREQ), ref_invsqrt(nums[j]));
          end
          j++;
        end
        if (c < 10) begin
          nums.push_back(bus.req_number[32*(n % NREQ) +: 32]);
          n++;
        end
      end
      tick();
    end
    bus.rsp_stall = 1'b0;
    checks++;
    if (j != 7 || n != 7) begin
      failures++;
      $display("FAIL stall_count: got %0d responses of %0d accepts expected 7", j, n);
    end
  endtask

  task automatic test_error();
    logic [NREQ-1:0] exp_ids [2];
    int unsigned     j;
    do_reset();
    exp_ids[0] = 4'b0010;
    exp_ids[1] = 4'b0100;
    j = 0;
    bus.req_number            = '0;
    bus.req_number[63:32]     = 32'hBF80_0000;
    bus.req_number[95:64]     = 32'h0000_0000;
    for (int c = 0; c < 2 + 3 * LAT; c++) begin
      bus.req_valid = (c == 0) ? 4'b0110 : (c == 1) ? 4'b0100 : 4'b0000;
      #2;
      if (c < 2) begin
        checks++;
        if (bus.req_ready !== exp_ids[c]) begin
          failures++;
          $display("FAIL err_grant c=%0d: got %b expected %b", c, bus.req_ready, exp_ids[c]);
        end
      end
      if (bus.rsp_valid !== '0) begin
        checks++;
        if (j > 1) begin
          failures++;
          $display("FAIL err_extra_rsp: got %b expected none", bus.rsp_valid);
        end else if (bus.rsp_valid !== exp_ids[j] || bus.rsp_error !== 1'b1) begin
          failures++;
          $display("FAIL err_rsp j=%0d: got %b err=%b expected %b err=1", j, bus.rsp_valid, bus.rsp_error, exp_ids[j]);
        end
        j++;
      end
      tick();
    end
    #2;
    checks++;
    if (j != 2 || tag_fault !== 1'b0) begin
      failures++;
      $display("FAIL err_done: got %0d rsps fault=%b expected 2/0", j, tag_fault);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      bus.req_valid = 4'b0111;
      for (int i = 0; i < NREQ; i++) bus.req_number[32*i +: 32] = rand_num(1'b0);
      #2;
      checks++;
      if (bus.req_ready !== (NREQ'(1) << c)) begin
        failures++;
        $display("FAIL mid_grant c=%0d: got %b expected %b", c, bus.req_ready, NREQ'(1) << c);
      end
      tick();
    end
    bus.req_valid = '0;
    rstn = 1'b0;
    #2;
    checks++;
    if (inflight !== CNTW'(3)) begin
      failures++;
      $display("FAIL mid_inflight: got %0d expected 3", inflight);
    end
    tick();
    rstn = 1'b1;
    #2;
    checks++;
    if (inflight !== '0 || bus.req_ready !== '0 || bus.rsp_valid !== '0 || tag_fault !== 1'b0) begin
      failures++;
      $display("FAIL mid_cleared: got inflight=%0d rdy=%b rsp=%b fault=%b expected 0", inflight, bus.req_ready,
               bus.rsp_valid, tag_fault);
    end
    tick();
    bus.req_valid = 4'b1010;
    #2;
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL mid_ptr: got %b expected 0010", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    for (int c = 0; c < LAT + 2; c++) tick();
    #2;
    checks++;
    if (tag_fault !== 1'b0 || inflight !== '0) begin
      failures++;
      $display("FAIL mid_after: got fault=%b inflight=%0d expected 0/0", tag_fault, inflight);
    end
  endtask

  task automatic test_fault();
    tick();
    #2;
    checks++;
    if (tag_fault !== 1'b0) begin
      failures++;
      $display("FAIL fault_pre: got %b expected 0", tag_fault);
    end
    tick();
    inject = 1'b1;
    tick();
    inject = 1'b0;
    #2;
    checks++;
    if (tag_fault !== 1'b1) begin
      failures++;
      $display("FAIL fault_set: got %b expected 1", tag_fault);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      #2;
      checks++;
      if (tag_fault !== 1'b1) begin
        failures++;
        $display("FAIL fault_sticky c=%0d: got %b expected 1", c, tag_fault);
      end
    end
    do_reset();
    #2;
    checks++;
    if (tag_fault !== 1'b0) begin
      failures++;
      $display("FAIL fault_clear: got %b expected 0", tag_fault);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 300 + 3 * LAT; c++) begin
      bus.req_valid = (c < 300) ? NREQ'($urandom) : '0;
      bus.rsp_stall = (c < 300) ? ($urandom_range(0, 4) == 0) : 1'b0;
      for (int i = 0; i < NREQ; i++) bus.req_number[32*i +: 32] = rand_num(1'b1);
      #2;
      checks++;
      if (bus.pipe_backprn !== !bus.rsp_stall || !$onehot0(bus.req_ready)) begin
        failures++;
        $display("FAIL rand_handshake c=%0d: got bp=%b rdy=%b stall=%b", c, bus.pipe_backprn, bus.req_ready, bus.rsp_stall);
      end
      tick();
    end
    #2;
    checks++;
    if (inflight !== '0 || tag_fault !== 1'b0) begin
      failures++;
      $display("FAIL rand_drain: got inflight=%0d fault=%b expected 0/0", inflight, tag_fault);
    end
  endtask

  initial begin
    rstn           = 1'b0;
    inject         = 1'b0;
    bus.req_valid  = '0;
    bus.req_number = '0;
    bus.rsp_stall  = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_error();
    test_reset_midflight();
    test_fault();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
